// File: rtl/if_id_reg_pkg.sv
// Constants and entry type shared by the IF/ID register, CP0 and the other stage registers.
package if_id_reg_pkg;

  localparam logic [4:0]  EXC_NONE  = 5'd0;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;
  localparam logic [31:0] TEXT_LO   = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI   = 32'h0000_6FFC;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcnxt;
    logic        bd;
    logic [4:0]  exc_code;
    logic        exc_valid;
    logic        valid;
  } id_entry_t;

  // Bubble entry: a nop with no PC, no exception and the valid bit clear.
  function automatic id_entry_t bubble();
    id_entry_t e;
    e           = '0;
    e.instr     = NOP_INSTR;
    e.exc_code  = EXC_NONE;
    return e;
  endfunction

endpackage

// File: rtl/if_id_reg_fetch_exc_check.sv
// Fetch address check: flags misaligned or out-of-text-segment instruction addresses (AdEL).
module fetch_exc_check #(
  parameter logic [31:0] TEXT_LO = if_id_reg_pkg::TEXT_LO,
  parameter logic [31:0] TEXT_HI = if_id_reg_pkg::TEXT_HI
) (
  input  logic [31:0] InstAddr,
  output logic        adel
);

  always_comb begin
    adel = (InstAddr[1:0] != 2'b00) || (InstAddr < TEXT_LO) || (InstAddr > TEXT_HI);
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetch results, tags AdEL faults, and stalls or flushes to a bubble.
module if_id_reg
  import if_id_reg_pkg::*;
#(
  parameter logic [31:0] TEXT_LO  = if_id_reg_pkg::TEXT_LO,
  parameter logic [31:0] TEXT_HI  = if_id_reg_pkg::TEXT_HI,
  parameter logic [4:0]  EXC_ADEL = if_id_reg_pkg::EXC_ADEL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Froze,
  input  logic        requestInt,
  input  logic        EretD,
  input  logic        BranchD,
  input  logic [31:0] InstAddr,
  input  logic [31:0] PCNxt,
  input  logic [31:0] InstrF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCNxtD,
  output logic        BDD,
  output logic [4:0]  ExcCodeD,
  output logic        ExcValidD,
  output logic        ValidD
);

  logic      adel;
  id_entry_t q;
  id_entry_t d;

  fetch_exc_check #(
    .TEXT_LO (TEXT_LO),
    .TEXT_HI (TEXT_HI)
  ) u_fetch_exc_check (
    .InstAddr (InstAddr),
    .adel     (adel)
  );

  // Interrupt flush outranks the stall; eret squash only applies when not stalled.
  always_comb begin
    d = q;
    if (requestInt) begin
      d = bubble();
    end else if (Froze) begin
      d = q;
    end else if (EretD) begin
      d = bubble();
    end else begin
      d.pc    = InstAddr;
      d.pcnxt = PCNxt;
      d.bd    = BranchD;
      d.valid = 1'b1;
      if (adel) begin
        d.instr     = NOP_INSTR;
        d.exc_valid = 1'b1;
        d.exc_code  = EXC_ADEL;
      end else begin
        d.instr     = InstrF;
        d.exc_valid = 1'b0;
        d.exc_code  = EXC_NONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

  assign InstrD    = q.instr;
  assign PCD       = q.pc;
  assign PCNxtD    = q.pcnxt;
  assign BDD       = q.bd;
  assign ExcCodeD  = q.exc_code;
  assign ExcValidD = q.exc_valid;
  assign ValidD    = q.valid;

endmodule
